// File: rtl/operand_stack.sv
// LIFO operand stack feeding the ALU: tos/nos are masked combinational reads,
// push/pop/replace act at the rising edge with sticky overflow/underflow flags.
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == CNT_W'(DEPTH));

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = AW'(sp_q);
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          sp_d  = sp_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) unf_d = 1'b1;
        else       sp_d  = sp_q - CNT_W'(1);
      end
      2'b11: begin
        // Replace top; on an empty stack this degrades to a plain push.
        wr_en = 1'b1;
        if (empty) begin
          wr_addr = '0;
          sp_d    = CNT_W'(1);
        end else begin
          wr_addr = AW'(sp_q - CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; reads of invalid slots are masked.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_addr] <= push_data;
  end

  assign tos = (sp_q >= CNT_W'(1)) ? mem_q[AW'(sp_q - CNT_W'(1))] : '0;
  assign nos = (sp_q >= CNT_W'(2)) ? mem_q[AW'(sp_q - CNT_W'(2))] : '0;

  assign count   = sp_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule
